// File: rtl/pwm_cfg_spi_loader.sv
// SPI-style config loader: shadows duty/max_value words received from the Arduino and presents them to pwm_module.
// Optional macro PWM_CFG_SPI_LOADER_PERIOD_SYNC_EN defers the shadow-to-active copy to the PWM period_end pulse.
module pwm_cfg_spi_loader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs_n,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] max_value,
    output logic             pending,
    output logic             frame_ok,
    output logic             frame_err
);

    localparam int unsigned CMD_W = 8;
    localparam int unsigned MAX_BITS = (WIDTH > CMD_W) ? WIDTH : CMD_W;
    localparam int unsigned CNT_W = $clog2(MAX_BITS) + 1;
    localparam logic [CMD_W-1:0] CMD_DUTY = 8'h01;
    localparam logic [CMD_W-1:0] CMD_MAX  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE,
        S_WAIT_CS
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CMD_W-1:0]   cmd_sr, cmd_sr_nxt;
    logic [WIDTH-1:0]   data_sr, data_sr_nxt;
    logic [WIDTH-1:0]   shadow_duty, shadow_duty_nxt;
    logic [WIDTH-1:0]   shadow_max, shadow_max_nxt;
    logic [WIDTH-1:0]   duty_nxt, max_value_nxt;
    logic               pending_nxt, frame_ok_nxt, frame_err_nxt;

    // [0],[1] are the two sync flops; [2] is the edge-detect history register
    logic [2:0]         sclk_sync, cs_sync;
    logic [1:0]         mosi_sync;

    logic               sclk_rise_c, cs_fall_c, cs_rise_c, mosi_bit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise_c = sclk_sync[1] & ~sclk_sync[2];
    assign cs_fall_c   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise_c   = cs_sync[1] & ~cs_sync[2];
    assign mosi_bit_c  = mosi_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            shadow_duty <= '0;
            shadow_max  <= '1;
            duty        <= '0;
            max_value   <= '1;
            pending     <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            cmd_sr      <= cmd_sr_nxt;
            data_sr     <= data_sr_nxt;
            shadow_duty <= shadow_duty_nxt;
            shadow_max  <= shadow_max_nxt;
            duty        <= duty_nxt;
            max_value   <= max_value_nxt;
            pending     <= pending_nxt;
            frame_ok    <= frame_ok_nxt;
            frame_err   <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        cmd_sr_nxt      = cmd_sr;
        data_sr_nxt     = data_sr;
        shadow_duty_nxt = shadow_duty;
        shadow_max_nxt  = shadow_max;
        duty_nxt        = duty;
        max_value_nxt   = max_value;
        pending_nxt     = pending;
        frame_ok_nxt    = 1'b0;
        frame_err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cs_fall_c) begin
                    state_nxt   = S_CMD;
                    bit_cnt_nxt = '0;
                end
            end
            S_CMD: begin
                if (cs_rise_c) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (sclk_rise_c) begin
                    cmd_sr_nxt = {cmd_sr[CMD_W-2:0], mosi_bit_c};
                    if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (cs_rise_c) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (sclk_rise_c) begin
                    data_sr_nxt = {data_sr[WIDTH-2:0], mosi_bit_c};
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (cmd_sr == CMD_DUTY) begin
                    shadow_duty_nxt = data_sr;
                    frame_ok_nxt    = 1'b1;
                end else if (cmd_sr == CMD_MAX) begin
                    shadow_max_nxt = data_sr;
                    frame_ok_nxt   = 1'b1;
                end else begin
                    frame_err_nxt = 1'b1;
                end
                // a cs_n release landing exactly on this cycle must not strand us in WAIT_CS
                state_nxt = cs_rise_c ? S_IDLE : S_WAIT_CS;
            end
            S_WAIT_CS: begin
                if (cs_rise_c) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

`ifdef PWM_CFG_SPI_LOADER_PERIOD_SYNC_EN
        // copy reads the old shadows; a write in the same cycle re-arms pending
        if (period_end && pending) begin
            duty_nxt      = shadow_duty;
            max_value_nxt = shadow_max;
            pending_nxt   = 1'b0;
        end
        if (frame_ok_nxt) begin
            pending_nxt = 1'b1;
        end
`else
        if (frame_ok_nxt) begin
            duty_nxt      = shadow_duty_nxt;
            max_value_nxt = shadow_max_nxt;
        end
        pending_nxt = 1'b0;
`endif
    end

`ifndef PWM_CFG_SPI_LOADER_PERIOD_SYNC_EN
    logic unused_period_end;
    assign unused_period_end = period_end;
`endif

endmodule
